vend_credit_ctrl: RTL and testbench

//  Parametrised vending controller. Accumulates multi-denomination credit, sells one of
//  N_ITEMS products at per-item prices, tracks stock, and returns change/refund coin by coin.

---
 rtl/vend_pkg.sv | 29 ++
 rtl/vend_change_gen.sv | 20 ++
 rtl/vend_credit_ctrl.sv | 148 ++++++++++++++
 tb/tb_vend_credit_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending credit controller.
// All money quantities are in units of 5c.
package vend_pkg;

    typedef enum logic [1:0] {
        C5   = 2'd0,
        C10  = 2'd1,
        C25  = 2'd2,
        SLUG = 2'd3
    } coin_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vstate_e;

    // A slug is worth nothing.
    function automatic logic [2:0] coin_value(input coin_e c);
        case (c)
            C5:      coin_value = 3'd1;
            C10:     coin_value = 3'd2;
            C25:     coin_value = 3'd5;
            default: coin_value = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change-coin chooser: the largest coin that still fits
// in the remaining credit.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output coin_e               chg_type
);

    always_comb begin
        chg_type = C5;
        if (credit >= CREDIT_W'(5))
            chg_type = C25;
        else if (credit >= CREDIT_W'(2))
            chg_type = C10;
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Vending controller: credit accumulation, item sale with stock tracking,
// and coin-by-coin change/refund through the hopper.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int                  N_ITEMS    = 4,
    parameter int                  CREDIT_W   = 8,
    // Item 0 lives in the low byte.
    parameter logic [N_ITEMS*8-1:0] PRICES    = {8'd3, 8'd3, 8'd4, 8'd5},
    parameter logic [3:0]          STOCK_INIT = 4'd8,
    parameter int                  MAX_CREDIT = 20,
    localparam int                 SEL_W      = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    output logic                coin_accept,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_item,
    input  logic                refund_req,
    output logic                disp_valid,
    output logic [SEL_W-1:0]    disp_item,
    input  logic                disp_ready,
    output logic                chg_valid,
    output logic [1:0]          chg_type,
    input  logic                chg_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_ITEMS-1:0]  sold_out,
    output logic                err_sel
);

    vstate_e             state;
    logic [3:0]          stock [N_ITEMS];
    coin_e               gen_type;
    logic                item_ok;
    logic [SEL_W-1:0]    sel_idx;
    logic [7:0]          sel_price;
    logic [CREDIT_W:0]   coin_sum;
    logic                sel_bad;
    logic                coin_bad;

    vend_change_gen #(.CREDIT_W(CREDIT_W)) u_change_gen (
        .credit   (credit),
        .chg_type (gen_type)
    );

    assign chg_type = gen_type;

    // Out-of-range selects are steered to item 0 so lookups stay in bounds;
    // item_ok still flags them as errors.
    always_comb begin
        item_ok   = (int'(sel_item) < N_ITEMS);
        sel_idx   = item_ok ? sel_item : '0;
        sel_price = PRICES[sel_idx*8 +: 8];
        sel_bad   = !item_ok || (stock[sel_idx] == 4'd0) ||
                    ({1'b0, credit} < (CREDIT_W+1)'(sel_price));
        coin_sum  = {1'b0, credit} + (CREDIT_W+1)'(coin_value(coin_e'(coin_type)));
        coin_bad  = (coin_e'(coin_type) == SLUG) ||
                    (coin_sum > (CREDIT_W+1)'(MAX_CREDIT));
    end

    always_comb begin
        for (int i = 0; i < N_ITEMS; i++)
            sold_out[i] = (stock[i] == 4'd0);
    end

    // Refund beats select beats coin; a losing coin is handed back.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= '0;
            coin_accept <= 1'b0;
            coin_reject <= 1'b0;
            err_sel     <= 1'b0;
            disp_valid  <= 1'b0;
            disp_item   <= '0;
            chg_valid   <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++)
                stock[i] <= STOCK_INIT;
        end else begin
            coin_accept <= 1'b0;
            coin_reject <= 1'b0;
            err_sel     <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    if (refund_req) begin
                        if (coin_valid)
                            coin_reject <= 1'b1;
                        if (credit != '0) begin
                            state     <= CHANGE;
                            chg_valid <= 1'b1;
                        end
                    end else if (sel_valid) begin
                        if (coin_valid)
                            coin_reject <= 1'b1;
                        if (state == CREDIT) begin
                            if (sel_bad) begin
                                err_sel <= 1'b1;
                            end else begin
                                credit         <= credit - CREDIT_W'(sel_price);
                                stock[sel_idx] <= stock[sel_idx] - 4'd1;
                                state          <= DISPENSE;
                                disp_valid     <= 1'b1;
                                disp_item      <= sel_item;
                            end
                        end
                    end else if (coin_valid) begin
                        if (coin_bad) begin
                            coin_reject <= 1'b1;
                        end else begin
                            coin_accept <= 1'b1;
                            credit      <= coin_sum[CREDIT_W-1:0];
                            state       <= CREDIT;
                        end
                    end
                end
                DISPENSE: begin
                    if (coin_valid)
                        coin_reject <= 1'b1;
                    if (disp_ready) begin
                        disp_valid <= 1'b0;
                        if (credit != '0) begin
                            state     <= CHANGE;
                            chg_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                CHANGE: begin
                    if (coin_valid)
                        coin_reject <= 1'b1;
                    if (chg_ready) begin
                        credit <= credit - CREDIT_W'(coin_value(gen_type));
                        if (credit == CREDIT_W'(coin_value(gen_type))) begin
                            state     <= IDLE;
                            chg_valid <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: directed scenarios then random traffic,
// every cycle compared against a transaction-level model of the machine.
module tb_vend_credit_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_type;
    logic       coin_accept;
    logic       coin_reject;
    logic       sel_valid;
    logic [1:0] sel_item;
    logic       refund_req;
    logic       disp_valid;
    logic [1:0] disp_item;
    logic       disp_ready;
    logic       chg_valid;
    logic [1:0] chg_type;
    logic       chg_ready;
    logic [7:0] credit;
    logic [3:0] sold_out;
    logic       err_sel;

    int vectors     = 0;
    int miscompares = 0;

    // Model: money in 5c units, stock per item, a pending dispense,
    // and the list of change coins still owed (as coin codes).
    int m_credit;
    int m_stock [4];
    int m_disp;
    int m_disp_item;
    int m_chg_q [$];
    int m_acc, m_rej, m_err;
    int price [4] = '{5, 4, 3, 3};

    vend_credit_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .coin_accept (coin_accept),
        .coin_reject (coin_reject),
        .sel_valid   (sel_valid),
        .sel_item    (sel_item),
        .refund_req  (refund_req),
        .disp_valid  (disp_valid),
        .disp_item   (disp_item),
        .disp_ready  (disp_ready),
        .chg_valid   (chg_valid),
        .chg_type    (chg_type),
        .chg_ready   (chg_ready),
        .credit      (credit),
        .sold_out    (sold_out),
        .err_sel     (err_sel)
    );

    always #5 clk = ~clk;

    function automatic int coinUnits(input int t);
        case (t)
            0:       return 1;
            1:       return 2;
            2:       return 5;
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic planChange();
        int c;
        c = m_credit;
        m_chg_q.delete();
        while (c >= 5) begin m_chg_q.push_back(2); c -= 5; end
        while (c >= 2) begin m_chg_q.push_back(1); c -= 2; end
        while (c >= 1) begin m_chg_q.push_back(0); c -= 1; end
    endtask

    task automatic modelStep(input bit r, input bit cv, input int ct, input bit sv,
                             input int si, input bit rf, input bit dr, input bit cr);
        m_acc = 0;
        m_rej = 0;
        m_err = 0;
        if (r) begin
            m_credit = 0;
            for (int i = 0; i < 4; i++) m_stock[i] = 8;
            m_disp = 0;
            m_chg_q.delete();
        end else if (m_disp != 0) begin
            if (cv) m_rej = 1;
            if (dr) begin
                m_disp = 0;
                if (m_credit > 0) planChange();
            end
        end else if (m_chg_q.size() > 0) begin
            if (cv) m_rej = 1;
            if (cr) m_credit -= coinUnits(m_chg_q.pop_front());
        end else if (rf) begin
            if (cv) m_rej = 1;
            if (m_credit > 0) planChange();
        end else if (sv) begin
            if (cv) m_rej = 1;
            if (m_credit > 0) begin
                if (m_stock[si] == 0 || m_credit < price[si]) begin
                    m_err = 1;
                end else begin
                    m_credit -= price[si];
                    m_stock[si]--;
                    m_disp = 1;
                    m_disp_item = si;
                end
            end
        end else if (cv) begin
            if (ct == 3 || m_credit + coinUnits(ct) > 20) m_rej = 1;
            else begin
                m_acc = 1;
                m_credit += coinUnits(ct);
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit cv, input int ct, input bit sv,
                                 input int si, input bit rf, input bit dr, input bit cr);
        int so;
        @(negedge clk);
        rst        = r;
        coin_valid = cv;
        coin_type  = ct[1:0];
        sel_valid  = sv;
        sel_item   = si[1:0];
        refund_req = rf;
        disp_ready = dr;
        chg_ready  = cr;
        @(posedge clk);
        #1;
        modelStep(r, cv, ct, sv, si, rf, dr, cr);
        so = 0;
        for (int i = 0; i < 4; i++) if (m_stock[i] == 0) so |= (1 << i);
        checkOutput("coin_accept", 32'(coin_accept), m_acc);
        checkOutput("coin_reject", 32'(coin_reject), m_rej);
        checkOutput("err_sel",     32'(err_sel),     m_err);
        checkOutput("disp_valid",  32'(disp_valid),  m_disp);
        if (m_disp != 0) checkOutput("disp_item", 32'(disp_item), m_disp_item);
        checkOutput("chg_valid",   32'(chg_valid),   (m_chg_q.size() > 0) ? 1 : 0);
        if (m_chg_q.size() > 0) checkOutput("chg_type", 32'(chg_type), m_chg_q[0]);
        checkOutput("credit",      32'(credit),      m_credit);
        checkOutput("sold_out",    32'(sold_out),    so);
    endtask

    task automatic drainAll();
        for (int k = 0; k < 20 && (m_disp != 0 || m_chg_q.size() > 0); k++)
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("drain_done", 32'(chg_valid | disp_valid), 0);
    endtask

    task automatic buyItem(input int item);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, item, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; coin_valid = 1'b0; coin_type = 2'd0; sel_valid = 1'b0;
        sel_item = 2'd0; refund_req = 1'b0; disp_ready = 1'b0; chg_ready = 1'b0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_credit", 32'(credit), 0);
        checkOutput("reset_sold_out", 32'(sold_out), 0);

        buyItem(2);
        checkOutput("sale2_item", 32'(disp_item), 2);
        checkOutput("sale2_credit", 32'(credit), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

        applyStimulus(0, 1, 2, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 2, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("sale0_credit", 32'(credit), 5);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("chg25_type", 32'(chg_type), 2);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("chg25_credit", 32'(credit), 0);

        // Refund of 20c with the hopper stalled: two 10c coins.
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("stall_type", 32'(chg_type), 1);
        drainAll();

        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 2, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 2, 0, 0, 0, 0, 0);
        checkOutput("cap_reject", 32'(coin_reject), 1);
        checkOutput("cap_credit", 32'(credit), 18);
        applyStimulus(0, 1, 3, 0, 0, 0, 0, 0);
        checkOutput("slug_reject", 32'(coin_reject), 1);
        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
        drainAll();

        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
        checkOutput("short_err", 32'(err_sel), 1);
        checkOutput("short_credit", 32'(credit), 2);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        drainAll();

        for (int n = 0; n < 8; n++) begin
            buyItem(3);
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        end
        checkOutput("soldout3", 32'(sold_out[3]), 1);
        buyItem(3);
        checkOutput("soldout3_err", 32'(err_sel), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        drainAll();

        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("rst_chg_valid", 32'(chg_valid), 0);
        checkOutput("rst_credit", 32'(credit), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            bit r, cv, sv, rf, dr, cr, busy;
            int ct, si;
            r    = ($urandom_range(0, 199) == 0);
            busy = (m_disp != 0) || (m_chg_q.size() > 0);
            sv   = ($urandom_range(0, 9) == 0);
            rf   = ($urandom_range(0, 29) == 0);
            cv   = ($urandom_range(0, 9) < 4);
            dr   = ($urandom_range(0, 1) == 1);
            cr   = ($urandom_range(0, 1) == 1);
            ct   = int'($urandom_range(0, 3));
            si   = int'($urandom_range(0, 3));
            // Keep a coin off a cycle where a select or an empty-credit refund
            // would contend with it outside a busy phase.
            if (cv && (sv || rf) && !busy && !(rf && m_credit > 0)) cv = 0;
            applyStimulus(r, cv, ct, sv, si, rf, dr, cr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
